uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NUM_REQ byte producers, e.g. a status beacon, an rx echo path and a debug dumper.
- Sits between the producers and the uart block's tx_en/tx_data/tx_busy interface.
- Grants are round-robin; one byte is sent per grant.
- Owns the tx_en launch handshake, so producers never touch the UART directly.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width; fixed to the UART frame width
LAUNCH_TIMEOUT, 1024, sys_clk cycles to wait for tx_busy to rise after tx_en before aborting
ID_W, $clog2(NUM_REQ), width of grant_id

Ports:
sys_clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-requester byte-valid, level; held until its ack
req_data  in  NUM_REQ*DATA_W  packed bytes; requester i owns bits [i*8+:8]
req_ack  out  NUM_REQ  one-cycle pulse: byte accepted by the UART
tx_en  out  1  to uart tx_en
tx_data  out  DATA_W  to uart tx_data; stable while tx_en=1
tx_busy  in  1  from uart tx_busy
grant_id  out  ID_W  index of the current or last granted requester
active  out  1  1 in LAUNCH or DRAIN
timeout_err  out  1  one-cycle pulse on launch abort

Behaviour:
- All outputs are registered.
- Reset values: tx_en=0, tx_data=0, req_ack=0, grant_id=0, active=0, timeout_err=0, FSM=IDLE, rr_ptr=0, timeout counter=0.
- Reset mid-transfer drops tx_en on the next edge. A UART frame already in flight is not stopped; the FSM still enters IDLE.
- IDLE:
  - If tx_busy=0 and |req, select the winner: first set bit of req scanning from rr_ptr upward, modulo NUM_REQ.
  - Next edge: latch req_data[winner] into tx_data, set grant_id=winner, tx_en=1, active=1, clear the counter, go to LAUNCH.
  - If tx_busy=1 in IDLE (foreign or leftover frame), wait; no grant.
- LAUNCH:
  - tx_en is held at 1 and tx_data is held stable.
  - On the first cycle tx_busy=1: next edge sets tx_en=0, pulses req_ack[grant_id] for one cycle, sets rr_ptr=grant_id+1 (wraps to 0 at NUM_REQ), and goes to DRAIN.
  - Otherwise the counter increments. When the counter reaches LAUNCH_TIMEOUT-1 with tx_busy still 0: next edge sets tx_en=0, pulses timeout_err, gives no ack, advances rr_ptr as above (no starvation from a dead requester), and goes to IDLE with active=0.
- DRAIN:
  - Wait for tx_busy=0, then next edge go to IDLE with active=0.
  - The earliest next grant is therefore the cycle after IDLE is re-entered. Minimum back-to-back spacing is frame time plus 2 cycles.
- Requests:
  - A requester may deassert req while its byte is in LAUNCH. The latched byte is still sent and req_ack still pulses; the requester ignores it.
  - A requester must drop or refresh req the cycle after its ack; a still-high req is treated as a new byte.
  - Requests arriving during LAUNCH or DRAIN wait for IDLE. Simultaneous requests are resolved only by rr_ptr.
- Latency: req rise in IDLE with tx_busy=0 gives tx_en=1 one cycle later, and req_ack one cycle after tx_busy is sampled high.
- Width rules: the counter is $clog2(LAUNCH_TIMEOUT)+1 bits. rr_ptr is ID_W bits with explicit wrap when NUM_REQ is not a power of two.

Decomposition:
- Package uart_arb_pkg holds:
  - state encoding ST_IDLE=2'd0, ST_LAUNCH=2'd1, ST_DRAIN=2'd2
  - UART_DATA_W=8
  - the default LAUNCH_TIMEOUT
- One sub-module, rr_pick: combinational round-robin priority select. Inputs req[NUM_REQ] and rr_ptr; outputs winner index and a valid flag.
- The FSM, latches and counter stay in uart_tx_arbiter.

Test Plan:
- Single requester: req[2]=1, data 8'h41, tx_busy model rises 3 cycles after tx_en, holds 20 cycles. Required: tx_en=1 one cycle after req, tx_data=8'h41; req_ack[2] pulses once the cycle after busy rises; tx_en=0 on that same edge; active falls after busy falls.
- Round-robin fairness: req=4'b1111 held, bytes 8'h10..8'h13. Required: grant_id sequence 0,1,2,3,0 with matching tx_data; each ack exactly once per byte.
- Pointer wrap with NUM_REQ=3: req=3'b101 held after grant to 2. Required: next grant is 0, then 2.
- Launch timeout: tx_busy tied 0, req[1]=1. Required: tx_en stays 1 for exactly 1024 cycles, then 0; timeout_err pulses once; no req_ack; the next grant goes to requester 2 if requesting.
- Busy at idle: tx_busy=1 externally with req[0]=1. Required: no tx_en while busy; grant one cycle after tx_busy falls.
- Reset mid-LAUNCH and mid-DRAIN: assert rst for 1 cycle. Required: next cycle tx_en=0, active=0, req_ack=0, grant_id=0; after release, first grant goes to the lowest requesting index.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int unsigned UART_DATA_W            = 8;
  localparam int unsigned DEFAULT_LAUNCH_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_DRAIN  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set request scanning upward from rr_ptr.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               valid
);

  // One extra bit holds rr_ptr+offset before the explicit modulo wrap.
  logic [ID_W:0]   sum;
  logic [ID_W-1:0] cand;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sum    = '0;
    cand   = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      cand = sum[ID_W-1:0];
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = UART_DATA_W,
  parameter int unsigned LAUNCH_TIMEOUT = DEFAULT_LAUNCH_TIMEOUT,
  parameter int unsigned ID_W           = $clog2(NUM_REQ)
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      tx_en,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [ID_W-1:0]           grant_id,
  output logic                      active,
  output logic                      timeout_err
);

  localparam int unsigned CNT_W = $clog2(LAUNCH_TIMEOUT) + 1;

  arb_state_e         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [CNT_W-1:0]   launch_cnt;
  logic [ID_W-1:0]    pick_id;
  logic               pick_valid;
  logic [ID_W-1:0]    next_ptr;
  logic [DATA_W-1:0]  req_bytes [NUM_REQ];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (pick_id),
    .valid  (pick_valid)
  );

  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_bytes[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Pointer moves past the granted requester whether the launch succeeded or timed out.
  assign next_ptr = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      launch_cnt  <= '0;
      tx_en       <= 1'b0;
      tx_data     <= '0;
      req_ack     <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      req_ack     <= '0;
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!tx_busy && pick_valid) begin
            tx_data    <= req_bytes[pick_id];
            grant_id   <= pick_id;
            tx_en      <= 1'b1;
            active     <= 1'b1;
            launch_cnt <= '0;
            state      <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (tx_busy) begin
            tx_en   <= 1'b0;
            req_ack <= NUM_REQ'(1) << grant_id;
            rr_ptr  <= next_ptr;
            state   <= ST_DRAIN;
          end else if (launch_cnt == CNT_W'(LAUNCH_TIMEOUT - 1)) begin
            tx_en       <= 1'b0;
            timeout_err <= 1'b1;
            rr_ptr      <= next_ptr;
            active      <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            launch_cnt <= launch_cnt + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (!tx_busy) begin
            active <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          tx_en  <= 1'b0;
          active <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized frames vs a round-robin model.
module tb_uart_tx_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned N3 = 3;
  localparam int unsigned LT = 1024;

  logic           sys_clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_ack;
  logic           tx_en;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic [1:0]     grant_id;
  logic           active;
  logic           timeout_err;

  logic [N3-1:0]   req3;
  logic [N3*8-1:0] req_data3;
  logic [N3-1:0]   req_ack3;
  logic            tx_en3;
  logic [7:0]      tx_data3;
  logic            busy3;
  logic [1:0]      grant_id3;
  logic            active3;
  logic            timeout_err3;

  int errors = 0;
  int checks = 0;
  int m_ptr  = 0;
  logic [7:0] b [N];

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(8), .LAUNCH_TIMEOUT(LT)) u_dut (
    .sys_clk(sys_clk), .rst(rst), .req(req), .req_data(req_data), .req_ack(req_ack),
    .tx_en(tx_en), .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id),
    .active(active), .timeout_err(timeout_err)
  );

  uart_tx_arbiter #(.NUM_REQ(N3), .DATA_W(8), .LAUNCH_TIMEOUT(16)) u_dut3 (
    .sys_clk(sys_clk), .rst(rst), .req(req3), .req_data(req_data3), .req_ack(req_ack3),
    .tx_en(tx_en3), .tx_data(tx_data3), .tx_busy(busy3), .grant_id(grant_id3),
    .active(active3), .timeout_err(timeout_err3)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Reference arbitration: first requester at or after ptr, modulo N.
  function automatic int model_pick(input logic [N-1:0] r, input int ptr);
    for (int i = 0; i < int'(N); i++) begin
      int k;
      k = (ptr + i) % int'(N);
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic load_bytes();
    req_data = {b[3], b[2], b[1], b[0]};
  endtask

  // One complete frame on the 4-requester instance, grant expected on the first tick.
  task automatic run_frame(input int exp_id, input logic [7:0] exp_data,
                           input int dly, input int hold, input bit drop_in_launch);
    tick();
    checks++;
    if (tx_en !== 1'b1 || grant_id !== 2'(exp_id) || tx_data !== exp_data || active !== 1'b1) begin
      errors++;
      $display("FAIL grant: tx_en=%b id=%0d data=%h active=%b, expected 1 %0d %h 1",
               tx_en, grant_id, tx_data, active, exp_id, exp_data);
    end
    checks++;
    if (timeout_err !== 1'b0 || req_ack !== '0) begin
      errors++;
      $display("FAIL grant_quiet: timeout_err=%b req_ack=%b, expected 0 0000", timeout_err, req_ack);
    end
    if (drop_in_launch) req = req & ~(N'(1) << exp_id);
    for (int c = 1; c < dly; c++) begin
      tick();
      checks++;
      if (tx_en !== 1'b1 || tx_data !== exp_data || req_ack !== '0) begin
        errors++;
        $display("FAIL launch_hold: tx_en=%b data=%h ack=%b, expected 1 %h 0000", tx_en, tx_data, req_ack, exp_data);
      end
    end
    tx_busy = 1'b1;
    tick();
    checks++;
    if (req_ack !== (N'(1) << exp_id) || tx_en !== 1'b0) begin
      errors++;
      $display("FAIL ack: req_ack=%b tx_en=%b, expected %b 0", req_ack, tx_en, N'(1) << exp_id);
    end
    for (int c = 1; c < hold; c++) begin
      tick();
      checks++;
      if (active !== 1'b1 || req_ack !== '0 || tx_en !== 1'b0) begin
        errors++;
        $display("FAIL drain: active=%b ack=%b tx_en=%b, expected 1 0000 0", active, req_ack, tx_en);
      end
    end
    tx_busy = 1'b0;
    tick();
    checks++;
    if (active !== 1'b0 || tx_en !== 1'b0) begin
      errors++;
      $display("FAIL drain_exit: active=%b tx_en=%b, expected 0 0", active, tx_en);
    end
    m_ptr = (exp_id + 1) % int'(N);
  endtask

  task automatic frame3(input int exp_id, input logic [7:0] exp_data);
    tick();
    checks++;
    if (tx_en3 !== 1'b1 || grant_id3 !== 2'(exp_id) || tx_data3 !== exp_data) begin
      errors++;
      $display("FAIL wrap3_grant: tx_en=%b id=%0d data=%h, expected 1 %0d %h", tx_en3, grant_id3, tx_data3, exp_id, exp_data);
    end
    busy3 = 1'b1;
    tick();
    checks++;
    if (req_ack3 !== (N3'(1) << exp_id)) begin
      errors++;
      $display("FAIL wrap3_ack: req_ack=%b, expected %b", req_ack3, N3'(1) << exp_id);
    end
    busy3 = 1'b0;
    tick();
    checks++;
    if (active3 !== 1'b0) begin
      errors++;
      $display("FAIL wrap3_idle: active=%b, expected 0", active3);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (tx_en !== 1'b0 || tx_data !== 8'h00 || req_ack !== '0 || grant_id !== 2'd0 ||
        active !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: tx_en=%b data=%h ack=%b id=%0d active=%b terr=%b, expected all zero",
               tag, tx_en, tx_data, req_ack, grant_id, active, timeout_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0;
    req3 = '0; req_data3 = '0; busy3 = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    m_ptr = 0;
  endtask

  task automatic test_round_robin();
    int seq [5] = '{0, 1, 2, 3, 0};
    b[0] = 8'h10; b[1] = 8'h11; b[2] = 8'h12; b[3] = 8'h13;
    load_bytes();
    req = 4'b1111;
    foreach (seq[k]) run_frame(seq[k], b[seq[k]], 2, 3, 1'b0);
    req = '0;
  endtask

  task automatic test_single();
    b[0] = 8'h00; b[1] = 8'h00; b[2] = 8'h41; b[3] = 8'h00;
    load_bytes();
    req = 4'b0100;
    run_frame(2, 8'h41, 3, 20, 1'b0);
    req = '0;
  endtask

  task automatic test_wrap3();
    req_data3 = {8'hA2, 8'hA1, 8'hA0};
    req3 = 3'b100;
    frame3(2, 8'hA2);
    req3 = 3'b101;
    frame3(0, 8'hA0);
    frame3(2, 8'hA2);
    req3 = '0;
  endtask

  task automatic test_timeout();
    int n, acks, pulses;
    b[1] = 8'h5A; b[2] = 8'hC3;
    load_bytes();
    req = 4'b0010;
    tick();
    checks++;
    if (tx_en !== 1'b1 || grant_id !== 2'd1 || tx_data !== 8'h5A) begin
      errors++;
      $display("FAIL timeout_grant: tx_en=%b id=%0d data=%h, expected 1 1 5a", tx_en, grant_id, tx_data);
    end
    req = 4'b0110;
    n = 1; acks = 0; pulses = 0;
    while (n < 2000) begin
      tick();
      if (req_ack !== '0) acks++;
      if (timeout_err === 1'b1) pulses++;
      if (tx_en !== 1'b1) break;
      n++;
    end
    checks++;
    if (n != int'(LT)) begin
      errors++;
      $display("FAIL timeout_len: tx_en high %0d cycles, expected %0d", n, LT);
    end
    checks++;
    if (pulses != 1 || acks != 0 || active !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort: pulses=%0d acks=%0d active=%b, expected 1 0 0", pulses, acks, active);
    end
    m_ptr = 2;
    run_frame(model_pick(req, m_ptr), 8'hC3, 2, 3, 1'b0);
    req = '0;
  endtask

  task automatic test_busy_idle();
    b[0] = 8'h77;
    load_bytes();
    tx_busy = 1'b1;
    req = 4'b0001;
    repeat (6) begin
      tick();
      checks++;
      if (tx_en !== 1'b0 || active !== 1'b0) begin
        errors++;
        $display("FAIL busy_idle: tx_en=%b active=%b, expected 0 0", tx_en, active);
      end
    end
    tx_busy = 1'b0;
    run_frame(model_pick(req, m_ptr), 8'h77, 1, 2, 1'b0);
    req = '0;
  endtask

  task automatic test_reset_mid();
    b[0] = 8'h01; b[1] = 8'hB1; b[2] = 8'h02; b[3] = 8'hB3;
    load_bytes();
    req = 4'b1010;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check_reset_outputs("reset_launch");
    rst = 1'b0;
    m_ptr = 0;
    run_frame(model_pick(req, m_ptr), 8'hB1, 2, 2, 1'b0);
    tick();
    tx_busy = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    checks++;
    if (tx_en !== 1'b0 || active !== 1'b0 || req_ack !== '0 || grant_id !== 2'd0) begin
      errors++;
      $display("FAIL reset_drain: tx_en=%b active=%b ack=%b id=%0d, expected 0 0 0000 0", tx_en, active, req_ack, grant_id);
    end
    rst = 1'b0;
    repeat (3) begin
      tick();
      checks++;
      if (tx_en !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy_hold: tx_en=%b, expected 0", tx_en);
      end
    end
    tx_busy = 1'b0;
    m_ptr = 0;
    run_frame(model_pick(req, m_ptr), 8'hB1, 1, 1, 1'b0);
    req = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] m;
    int w;
    repeat (30) begin
      for (int i = 0; i < int'(N); i++) b[i] = 8'($urandom);
      load_bytes();
      m = N'($urandom_range(1, 15));
      req = m;
      w = model_pick(m, m_ptr);
      run_frame(w, b[w], int'($urandom_range(1, 4)), int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_wrap3();
    test_timeout();
    test_busy_idle();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
